// File: rtl/decode_execute_register.sv
// ID/EX pipeline register with RAW hazard resolution: operand forwarding, load-use stall and bubble insertion.
// Build option DEC_EX_FWD_EN: when defined, EX/MEM results are forwarded; otherwise dependent instructions stall until the producer retires.
module decode_execute_register #(
    parameter int DATA_W = 32,
    parameter int ADR_W  = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Flush,
    input  logic              Hold,
    input  logic              In_Valid,
    input  logic [ADR_W-1:0]  Rs_Adr,
    input  logic [ADR_W-1:0]  Rt_Adr,
    input  logic              Rs_Used,
    input  logic              Rt_Used,
    input  logic [DATA_W-1:0] Rs_Data,
    input  logic [DATA_W-1:0] Rt_Data,
    input  logic [DATA_W-1:0] Imm_In,
    input  logic [ADR_W-1:0]  Dest_Adr_In,
    input  logic              Dest_WEn_In,
    input  logic              Is_Load_In,
    input  logic [CTRL_W-1:0] Ctrl_In,
    input  logic [DATA_W-1:0] Ex_Result,
    input  logic [ADR_W-1:0]  Mem_Dest_Adr,
    input  logic              Mem_WEn,
    input  logic [DATA_W-1:0] Mem_Result,
    output logic              Ex_Valid,
    output logic [DATA_W-1:0] Ex_Op_A,
    output logic [DATA_W-1:0] Ex_Op_B,
    output logic [DATA_W-1:0] Ex_Imm,
    output logic [ADR_W-1:0]  Ex_Dest_Adr,
    output logic              Ex_Dest_WEn,
    output logic              Ex_Is_Load,
    output logic [CTRL_W-1:0] Ex_Ctrl,
    output logic              Stall_Out,
    output logic [CNT_W-1:0]  Stall_Count
);

    logic              ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic              hazard;
    logic              stall_raw;
    logic [DATA_W-1:0] op_a, op_b;

    // Register r0 is hard-wired zero, so it never produces a dependency.
    assign ex_hit_rs  = Ex_Valid && Ex_Dest_WEn && (Ex_Dest_Adr == Rs_Adr) && (Rs_Adr != '0);
    assign ex_hit_rt  = Ex_Valid && Ex_Dest_WEn && (Ex_Dest_Adr == Rt_Adr) && (Rt_Adr != '0);
    assign mem_hit_rs = Mem_WEn && (Mem_Dest_Adr == Rs_Adr) && (Rs_Adr != '0);
    assign mem_hit_rt = Mem_WEn && (Mem_Dest_Adr == Rt_Adr) && (Rt_Adr != '0);

`ifdef DEC_EX_FWD_EN
    always_comb begin
        op_a = Rs_Data;
        op_b = Rt_Data;
        if (ex_hit_rs)
            op_a = Ex_Result;
        else if (mem_hit_rs)
            op_a = Mem_Result;
        if (ex_hit_rt)
            op_b = Ex_Result;
        else if (mem_hit_rt)
            op_b = Mem_Result;
    end

    // Only a load in EX cannot be forwarded in time; one bubble lets MEM forwarding take over.
    assign hazard = In_Valid && Ex_Is_Load &&
                    ((Rs_Used && ex_hit_rs) || (Rt_Used && ex_hit_rt));
`else
    logic unused_fwd;
    assign unused_fwd = ^{Ex_Result, Mem_Result};
    assign op_a = Rs_Data;
    assign op_b = Rt_Data;

    // Without forwarding, wait until the producer has left both EX and MEM.
    assign hazard = In_Valid &&
                    ((Rs_Used && (ex_hit_rs || mem_hit_rs)) ||
                     (Rt_Used && (ex_hit_rt || mem_hit_rt)));
`endif

    always_comb begin
        stall_raw = 1'b0;
        if (Flush)
            stall_raw = 1'b0;
        else if (Hold)
            stall_raw = 1'b1;
        else
            stall_raw = hazard;
    end

    assign Stall_Out = Reset_n && stall_raw;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Ex_Valid    <= 1'b0;
            Ex_Op_A     <= '0;
            Ex_Op_B     <= '0;
            Ex_Imm      <= '0;
            Ex_Dest_Adr <= '0;
            Ex_Dest_WEn <= 1'b0;
            Ex_Is_Load  <= 1'b0;
            Ex_Ctrl     <= '0;
            Stall_Count <= '0;
        end else begin
            if (Stall_Out && (Stall_Count != '1))
                Stall_Count <= Stall_Count + 1'b1;
            if (Flush || (!Hold && hazard)) begin
                Ex_Valid    <= 1'b0;
                Ex_Op_A     <= '0;
                Ex_Op_B     <= '0;
                Ex_Imm      <= '0;
                Ex_Dest_Adr <= '0;
                Ex_Dest_WEn <= 1'b0;
                Ex_Is_Load  <= 1'b0;
                Ex_Ctrl     <= '0;
            end else if (!Hold) begin
                Ex_Valid    <= In_Valid;
                Ex_Op_A     <= op_a;
                Ex_Op_B     <= op_b;
                Ex_Imm      <= Imm_In;
                Ex_Dest_Adr <= Dest_Adr_In;
                Ex_Dest_WEn <= Dest_WEn_In && In_Valid;
                Ex_Is_Load  <= Is_Load_In;
                Ex_Ctrl     <= Ctrl_In;
            end
        end
    end

endmodule

// File: tb/tb_decode_execute_register.sv
// Directed bench for decode_execute_register; expectations follow DEC_EX_FWD_EN when it is defined.
module tb_decode_execute_register;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Flush, Hold, In_Valid;
    logic [4:0]  Rs_Adr, Rt_Adr;
    logic        Rs_Used, Rt_Used;
    logic [31:0] Rs_Data, Rt_Data, Imm_In;
    logic [4:0]  Dest_Adr_In;
    logic        Dest_WEn_In, Is_Load_In;
    logic [7:0]  Ctrl_In;
    logic [31:0] Ex_Result;
    logic [4:0]  Mem_Dest_Adr;
    logic        Mem_WEn;
    logic [31:0] Mem_Result;
    logic        Ex_Valid;
    logic [31:0] Ex_Op_A, Ex_Op_B, Ex_Imm;
    logic [4:0]  Ex_Dest_Adr;
    logic        Ex_Dest_WEn, Ex_Is_Load;
    logic [7:0]  Ex_Ctrl;
    logic        Stall_Out;
    logic [15:0] Stall_Count;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt = 0;

    always #5 Clock = ~Clock;

    decode_execute_register dut (
        .Clock(Clock), .Reset_n(Reset_n), .Flush(Flush), .Hold(Hold), .In_Valid(In_Valid),
        .Rs_Adr(Rs_Adr), .Rt_Adr(Rt_Adr), .Rs_Used(Rs_Used), .Rt_Used(Rt_Used),
        .Rs_Data(Rs_Data), .Rt_Data(Rt_Data), .Imm_In(Imm_In),
        .Dest_Adr_In(Dest_Adr_In), .Dest_WEn_In(Dest_WEn_In), .Is_Load_In(Is_Load_In),
        .Ctrl_In(Ctrl_In), .Ex_Result(Ex_Result), .Mem_Dest_Adr(Mem_Dest_Adr),
        .Mem_WEn(Mem_WEn), .Mem_Result(Mem_Result),
        .Ex_Valid(Ex_Valid), .Ex_Op_A(Ex_Op_A), .Ex_Op_B(Ex_Op_B), .Ex_Imm(Ex_Imm),
        .Ex_Dest_Adr(Ex_Dest_Adr), .Ex_Dest_WEn(Ex_Dest_WEn), .Ex_Is_Load(Ex_Is_Load),
        .Ex_Ctrl(Ex_Ctrl), .Stall_Out(Stall_Out), .Stall_Count(Stall_Count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic dec(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ru, input logic tu,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                       input logic [4:0] dst, input logic wen, input logic ld, input logic [7:0] ctl);
        In_Valid = v;  Rs_Adr = rs;  Rt_Adr = rt;  Rs_Used = ru;  Rt_Used = tu;
        Rs_Data = rsd; Rt_Data = rtd; Imm_In = imm; Dest_Adr_In = dst;
        Dest_WEn_In = wen; Is_Load_In = ld; Ctrl_In = ctl;
        Flush = 1'b0; Hold = 1'b0; Mem_WEn = 1'b0; Mem_Dest_Adr = 5'd0;
        Ex_Result = 32'hE0E0_E0E0; Mem_Result = 32'hD0D0_D0D0;
    endtask

    initial begin
        Reset_n = 1'b0;
        dec(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 8'h00);
        #3;
        check("rst_valid", Ex_Valid, 1'b0);
        check("rst_stall", Stall_Out, 1'b0);
        check("rst_cnt", Stall_Count, 16'd0);
        #4 Reset_n = 1'b1;

        // plain capture
        dec(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 32'h1111, 32'h2222, 32'h33, 5'd4, 1'b1, 1'b0, 8'hA5);
        #1 check("cap_stall", Stall_Out, 1'b0);
        tick();
        check("cap_valid", Ex_Valid, 1'b1);
        check("cap_op_a", Ex_Op_A, 32'h1111);
        check("cap_op_b", Ex_Op_B, 32'h2222);
        check("cap_imm", Ex_Imm, 32'h33);
        check("cap_dest", Ex_Dest_Adr, 5'd4);
        check("cap_wen", Ex_Dest_WEn, 1'b1);
        check("cap_ctrl", Ex_Ctrl, 8'hA5);

        // invalid instruction still captures, valid/wen forced low
        dec(1'b0, 5'd4, 5'd0, 1'b1, 1'b0, 32'h4444, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0, 8'h01);
        Ex_Result = 32'h77;
        #1 check("inv_stall", Stall_Out, 1'b0);
        tick();
        check("inv_valid", Ex_Valid, 1'b0);
        check("inv_wen", Ex_Dest_WEn, 1'b0);
        check("inv_dest", Ex_Dest_Adr, 5'd6);
`ifdef DEC_EX_FWD_EN
        check("inv_op_a", Ex_Op_A, 32'h77);
`else
        check("inv_op_a", Ex_Op_A, 32'h4444);
`endif

        // r0 is never a dependency
        dec(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1, 8'h02);
        #1 tick();
        dec(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 8'h03);
        Ex_Result = 32'h55; Mem_Dest_Adr = 5'd0; Mem_WEn = 1'b1; Mem_Result = 32'h66;
        #1 check("r0_stall", Stall_Out, 1'b0);
        tick();
        check("r0_valid", Ex_Valid, 1'b1);
        check("r0_op_a", Ex_Op_A, 32'h0);

`ifdef DEC_EX_FWD_EN
        // EX beats MEM, then load-use with one bubble
        dec(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 8'h04);
        #1 tick();
        dec(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 32'h99, 32'h0, 32'h0, 5'd3, 1'b1, 1'b1, 8'h05);
        Ex_Result = 32'h11; Mem_Dest_Adr = 5'd5; Mem_WEn = 1'b1; Mem_Result = 32'h22;
        #1 check("fwd_stall", Stall_Out, 1'b0);
        tick();
        check("fwd_ex_prio", Ex_Op_A, 32'h11);
        dec(1'b1, 5'd0, 5'd3, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 8'h06);
        #1 check("lu_stall", Stall_Out, 1'b1);
        tick(); exp_cnt++;
        check("lu_bubble", Ex_Valid, 1'b0);
        check("lu_cnt", Stall_Count, exp_cnt);
        Mem_Dest_Adr = 5'd3; Mem_WEn = 1'b1; Mem_Result = 32'hCAFE;
        #1 check("lu_stall_end", Stall_Out, 1'b0);
        tick();
        check("lu_valid", Ex_Valid, 1'b1);
        check("lu_op_b", Ex_Op_B, 32'hCAFE);
`else
        // ALU dependency stalls while producer is in EX, then in MEM
        dec(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 8'h04);
        #1 tick();
        dec(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 32'hBEEF, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 8'h05);
        #1 check("dep_stall_ex", Stall_Out, 1'b1);
        tick(); exp_cnt++;
        check("dep_bubble1", Ex_Valid, 1'b0);
        check("dep_cnt1", Stall_Count, exp_cnt);
        Mem_Dest_Adr = 5'd7; Mem_WEn = 1'b1;
        #1 check("dep_stall_mem", Stall_Out, 1'b1);
        tick(); exp_cnt++;
        check("dep_bubble2", Ex_Valid, 1'b0);
        Mem_WEn = 1'b0;
        #1 check("dep_stall_end", Stall_Out, 1'b0);
        tick();
        check("dep_valid", Ex_Valid, 1'b1);
        check("dep_op_a", Ex_Op_A, 32'hBEEF);
        check("dep_cnt2", Stall_Count, exp_cnt);
`endif

        // hazard + hold + flush: flush wins
        dec(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1, 8'h5A);
        #1 tick();
        dec(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 32'h9, 32'h0, 32'h1, 5'd2, 1'b1, 1'b0, 8'hFF);
        Hold = 1'b1; Flush = 1'b1;
        #1 check("hhf_stall", Stall_Out, 1'b0);
        tick();
        check("hhf_valid", Ex_Valid, 1'b0);
        check("hhf_op_a", Ex_Op_A, 32'h0);
        check("hhf_ctrl", Ex_Ctrl, 8'h00);
        check("hhf_load", Ex_Is_Load, 1'b0);
        check("hhf_cnt", Stall_Count, exp_cnt);

        // hold freezes for 3 cycles
        dec(1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 32'hABCD, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0, 8'h3C);
        #1 tick();
        check("hold_pre", Ex_Op_A, 32'hABCD);
        dec(1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 32'h1234, 32'h0, 32'h0, 5'd11, 1'b1, 1'b0, 8'hC3);
        Hold = 1'b1;
        #1 check("hold_stall", Stall_Out, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(); exp_cnt++;
        end
        check("hold_op_a", Ex_Op_A, 32'hABCD);
        check("hold_ctrl", Ex_Ctrl, 8'h3C);
        check("hold_dest", Ex_Dest_Adr, 5'd10);
        check("hold_cnt", Stall_Count, exp_cnt);

        // reset in the middle of a load-use stall
        dec(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1, 8'h11);
        #1 tick();
        dec(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 32'h5, 32'h0, 32'h0, 5'd12, 1'b1, 1'b0, 8'h22);
        #1 check("mid_stall", Stall_Out, 1'b1);
        #1 Reset_n = 1'b0;
        #1;
        check("mid_rst_valid", Ex_Valid, 1'b0);
        check("mid_rst_dest", Ex_Dest_Adr, 5'd0);
        check("mid_rst_stall", Stall_Out, 1'b0);
        check("mid_rst_cnt", Stall_Count, 16'd0);
        #2 Reset_n = 1'b1;
        #1 check("post_rst_stall", Stall_Out, 1'b0);
        tick();
        check("post_rst_valid", Ex_Valid, 1'b1);
        check("post_rst_op_a", Ex_Op_A, 32'h5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_execute_register.md
Name: decode_execute_register

Overview:
- ID/EX pipeline register on the consuming side of the register file.
- Captures both read operands and the decode controls, and resolves RAW hazards.
- Forwards EX and MEM results into the captured operands.
- Detects load-use hazards, stalls the front end and inserts bubbles.
- WB-to-ID hazards are already covered by the register file's write-through bypass, so this block never handles them.

Parameters:
- DATA_W, 32, operand/result width
- ADR_W, 5, register address width
- CTRL_W, 8, opaque EX/MEM/WB control bundle width
- CNT_W, 16, stall counter width

Ports:
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- Flush  in  1  kill the instruction in decode (branch redirect)
- Hold  in  1  downstream back-pressure; freezes this stage
- In_Valid  in  1  decode holds a valid instruction
- Rs_Adr, Rt_Adr  in  ADR_W  source addresses (same values driven to register file read ports 1/2)
- Rs_Used, Rt_Used  in  1  source actually consumed
- Rs_Data, Rt_Data  in  DATA_W  register file read data 1/2
- Imm_In  in  DATA_W  sign-extended immediate
- Dest_Adr_In  in  ADR_W  destination address
- Dest_WEn_In  in  1  instruction writes a register
- Is_Load_In  in  1  instruction is a load
- Ctrl_In  in  CTRL_W  control bundle
- Ex_Result  in  DATA_W  combinational ALU result of the instruction in EX
- Mem_Dest_Adr  in  ADR_W  destination of the instruction in MEM
- Mem_WEn  in  1  MEM instruction writes a register
- Mem_Result  in  DATA_W  MEM stage result (load data or ALU result)
- Ex_Valid, Ex_Op_A, Ex_Op_B, Ex_Imm, Ex_Dest_Adr, Ex_Dest_WEn, Ex_Is_Load, Ex_Ctrl  out  registered EX-stage fields
- Stall_Out  out  1  combinational; freezes PC and IF/ID
- Stall_Count  out  CNT_W  saturating count of cycles with Stall_Out=1

Behaviour:
- Reset (Reset_n=0, async):
  - all registered outputs and Stall_Count = 0.
  - Stall_Out = 0 while in reset.
- Address 0 is never a hazard or forwarding source; matches with Dest/Mem address 0 are ignored.
- Forwarding, operand A (operand B identical using Rt):
  - priority 1, EX: Ex_Valid & Ex_Dest_WEn & Ex_Dest_Adr==Rs_Adr -> Ex_Result.
  - priority 2, MEM: Mem_WEn & Mem_Dest_Adr==Rs_Adr -> Mem_Result.
  - otherwise -> Rs_Data.
- Load-use:
  - Hazard = In_Valid & Ex_Valid & Ex_Is_Load & Ex_Dest_WEn & ((Rs_Used & match Rs) | (Rt_Used & match Rt)).
  - Stall lasts exactly 1 cycle; on the next cycle the load is in MEM and MEM forwarding supplies the data.
- Per-edge update, in priority order:
  1. Flush: load bubble (Ex_Valid=0, Ex_Dest_WEn=0, Ex_Is_Load=0, Ex_Ctrl=0, data fields 0). Stall_Out=0.
  2. Hold: all registers keep their value. Stall_Out=1.
  3. Hazard: load bubble. Stall_Out=1.
  4. Else: capture the forwarded operands, Imm_In and controls. Ex_Valid=In_Valid.
- Latency: 1 cycle from decode to EX outputs.
- With In_Valid=0 the register still captures, but Ex_Valid=0 and Ex_Dest_WEn is forced 0.
- Stall_Count increments at each edge where Stall_Out=1 and saturates at all-ones.
- Reset mid-stall clears all state immediately; the first post-reset cycle has no hazard because Ex_Valid=0.

Optional Feature:
- Macro: DEC_EX_FWD_EN.
- Defined: forwarding exactly as above.
- Undefined:
  - No forwarding muxes; operands always come from Rs_Data/Rt_Data.
  - Hazard becomes any used-source match with the EX destination (EX valid and writing) or the MEM destination (Mem_WEn), load or not.
  - Stall persists until no match remains: 2 cycles for a dependency on EX, 1 cycle for a dependency on MEM. Bubbles are inserted each stall cycle.
- Hold/Flush priority is unchanged in both builds.

Test Plan:
- Reset_n low mid-operation with Ex_Valid=1 -> all outputs 0 asynchronously; Stall_Count=0.
- EX add writing r5, Ex_Result=0x11; decode uses Rs=r5, Rs_Data=0x99 -> next cycle Ex_Op_A=0x11. Same case with MEM writing r5=0x22 as well -> EX value 0x11 still wins.
- Load to r3 in EX; decode uses Rt=r3 -> Stall_Out=1 for exactly 1 cycle, then a bubble (Ex_Valid=0). Next cycle Mem_Result=0xCAFE -> Ex_Op_B=0xCAFE; Stall_Count=1.
- EX load writing r0; decode uses r0, Rs_Data=0 -> no stall; Ex_Op_A=0.
- Hazard, Hold and Flush asserted together -> Stall_Out=0 and a bubble is loaded. Hold alone for 3 cycles -> outputs frozen, Stall_Count+=3.
- DEC_EX_FWD_EN undefined: ALU op writing r7 in EX, dependent op in decode -> 2 stall cycles, then Ex_Op_A=Rs_Data from the register file.
